// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register. freeze from the memory stage holds the register contents.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic [3:0]  exe_cmd,
    input  logic [1:0]  br_type,
    input  logic [1:0]  mem_sig,
    input  logic        wb_en,
    input  logic [4:0]  dest,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [31:0] reg2,
    input  logic [31:0] pc,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [4:0]  src_st,
    input  logic        mem_fw_en,
    input  logic [4:0]  mem_fw_dest,
    input  logic [31:0] mem_fw_data,
    input  logic        wb_fw_en,
    input  logic [4:0]  wb_fw_dest,
    input  logic [31:0] wb_fw_data,
    output logic        br_taken,
    output logic [31:0] br_addr,
    output logic        wb_en_o,
    output logic [1:0]  mem_sig_o,
    output logic [4:0]  dest_o,
    output logic [31:0] alu_res_o,
    output logic [31:0] st_data_o
);

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_s;
    logic [31:0] alu_res;
    logic        br_cond;

    logic        wb_en_d,   wb_en_q;
    logic [1:0]  mem_sig_d, mem_sig_q;
    logic [4:0]  dest_d,    dest_q;
    logic [31:0] alu_res_d, alu_res_q;
    logic [31:0] st_data_d, st_data_q;

    // MEM stage is younger than WB, so it wins; r0 is hardwired and never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [31:0] raw,
        input logic [4:0]  s,
        input logic        m_en,
        input logic [4:0]  m_dest,
        input logic [31:0] m_data,
        input logic        w_en,
        input logic [4:0]  w_dest,
        input logic [31:0] w_data
    );
        logic [31:0] sel;
        sel = raw;
        if (s != 5'd0 && m_en && m_dest == s) begin
            sel = m_data;
        end else if (s != 5'd0 && w_en && w_dest == s) begin
            sel = w_data;
        end
        return sel;
    endfunction

    always_comb begin
        op_a = fwd_sel(val1, src1, mem_fw_en, mem_fw_dest, mem_fw_data,
                       wb_fw_en, wb_fw_dest, wb_fw_data);
        op_b = fwd_sel(val2, src2, mem_fw_en, mem_fw_dest, mem_fw_data,
                       wb_fw_en, wb_fw_dest, wb_fw_data);
        op_s = fwd_sel(reg2, src_st, mem_fw_en, mem_fw_dest, mem_fw_data,
                       wb_fw_en, wb_fw_dest, wb_fw_data);
    end

    always_comb begin
        alu_res = 32'd0;
        case (exe_cmd)
            CMD_ADD: alu_res = op_a + op_b;
            CMD_SUB: alu_res = op_a - op_b;
            CMD_AND: alu_res = op_a & op_b;
            CMD_OR:  alu_res = op_a | op_b;
            CMD_NOR: alu_res = ~(op_a | op_b);
            CMD_XOR: alu_res = op_a ^ op_b;
            CMD_SLL: alu_res = op_a << op_b[4:0];
            CMD_SRA: alu_res = $signed(op_a) >>> op_b[4:0];
            CMD_SRL: alu_res = op_a >> op_b[4:0];
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            BR_NONE: br_cond = 1'b0;
            BR_BEZ:  br_cond = (op_a == 32'd0);
            BR_BNE:  br_cond = (op_a != op_s);
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    // A frozen cycle must not flush IF/ID; the branch re-resolves once unfrozen.
    assign br_taken = br_cond & ~freeze;
    assign br_addr  = pc + {val2[29:0], 2'b00};

    always_comb begin
        wb_en_d   = wb_en_q;
        mem_sig_d = mem_sig_q;
        dest_d    = dest_q;
        alu_res_d = alu_res_q;
        st_data_d = st_data_q;
        if (!freeze) begin
            wb_en_d   = wb_en;
            mem_sig_d = mem_sig;
            dest_d    = dest;
            alu_res_d = alu_res;
            st_data_d = op_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q   <= 1'b0;
            mem_sig_q <= 2'b00;
            dest_q    <= 5'd0;
            alu_res_q <= 32'd0;
            st_data_q <= 32'd0;
        end else begin
            wb_en_q   <= wb_en_d;
            mem_sig_q <= mem_sig_d;
            dest_q    <= dest_d;
            alu_res_q <= alu_res_d;
            st_data_q <= st_data_d;
        end
    end

    assign wb_en_o   = wb_en_q;
    assign mem_sig_o = mem_sig_q;
    assign dest_o    = dest_q;
    assign alu_res_o = alu_res_q;
    assign st_data_o = st_data_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus randomized traffic
// against an arithmetic reference model.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [3:0]  exe_cmd;
    logic [1:0]  br_type;
    logic [1:0]  mem_sig;
    logic        wb_en;
    logic [4:0]  dest;
    logic [31:0] val1, val2, reg2, pc;
    logic [4:0]  src1, src2, src_st;
    logic        mem_fw_en;
    logic [4:0]  mem_fw_dest;
    logic [31:0] mem_fw_data;
    logic        wb_fw_en;
    logic [4:0]  wb_fw_dest;
    logic [31:0] wb_fw_data;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        wb_en_o;
    logic [1:0]  mem_sig_o;
    logic [4:0]  dest_o;
    logic [31:0] alu_res_o;
    logic [31:0] st_data_o;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .exe_cmd(exe_cmd), .br_type(br_type), .mem_sig(mem_sig),
        .wb_en(wb_en), .dest(dest),
        .val1(val1), .val2(val2), .reg2(reg2), .pc(pc),
        .src1(src1), .src2(src2), .src_st(src_st),
        .mem_fw_en(mem_fw_en), .mem_fw_dest(mem_fw_dest), .mem_fw_data(mem_fw_data),
        .wb_fw_en(wb_fw_en), .wb_fw_dest(wb_fw_dest), .wb_fw_data(wb_fw_data),
        .br_taken(br_taken), .br_addr(br_addr),
        .wb_en_o(wb_en_o), .mem_sig_o(mem_sig_o), .dest_o(dest_o),
        .alu_res_o(alu_res_o), .st_data_o(st_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(input logic [31:0] raw, input logic [4:0] s);
        if (s != 0 && mem_fw_en && mem_fw_dest == s) return mem_fw_data;
        if (s != 0 && wb_fw_en && wb_fw_dest == s) return wb_fw_data;
        return raw;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, p;
        ua = a;
        ub = b;
        p = 1;
        for (int k = 0; k < int'(ub % 32); k++) p = p * 2;
        case (cmd)
            4'd0:  return 32'(ua + ub);
            4'd2:  return 32'(ua + 64'h1_0000_0000 - ub);
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return 32'hFFFF_FFFF - (a | b);
            4'd7:  return a ^ b;
            4'd8:  return 32'(ua * p);
            4'd9:  return a[31] ? 32'(64'hFFFF_FFFF - ((64'hFFFF_FFFF - ua) / p)) : 32'(ua / p);
            4'd10: return 32'(ua / p);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_taken(input logic [1:0] bt, input logic [31:0] a,
                                     input logic [31:0] s, input logic frz);
        logic c;
        c = (bt == 2'd1) ? (a == 0) : (bt == 2'd2) ? (a != s) : (bt == 2'd3);
        return c && !frz;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] p, input logic [31:0] imm);
        longint unsigned sum;
        sum = longint'(p) + longint'(imm) * 4;
        return 32'(sum);
    endfunction

    // ---------------- helpers ----------------
    task automatic clear_inputs();
        freeze = 0; exe_cmd = 0; br_type = 0; mem_sig = 0; wb_en = 0; dest = 0;
        val1 = 0; val2 = 0; reg2 = 0; pc = 0; src1 = 0; src2 = 0; src_st = 0;
        mem_fw_en = 0; mem_fw_dest = 0; mem_fw_data = 0;
        wb_fw_en = 0; wb_fw_dest = 0; wb_fw_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1;
        exe_cmd = 4'd0; val1 = 32'h1234; val2 = 32'h1; reg2 = 32'h55;
        wb_en = 1; mem_sig = 2'b10; dest = 5'd9;
        step();
        #2 rst = 0;
        #1;
        assert_cnt++;
        if ({wb_en_o, mem_sig_o, dest_o, alu_res_o, st_data_o} !== 72'd0) begin
            fail_cnt++;
            $display("FAIL reset_async got=%h exp=0", {wb_en_o, mem_sig_o, dest_o, alu_res_o, st_data_o});
        end
        step();
        assert_cnt++;
        if ({wb_en_o, mem_sig_o, dest_o, alu_res_o, st_data_o} !== 72'd0) begin
            fail_cnt++;
            $display("FAIL reset_hold got=%h exp=0", {wb_en_o, mem_sig_o, dest_o, alu_res_o, st_data_o});
        end
        #3 rst = 1;
        #1;
        assert_cnt++;
        if (alu_res_o !== 32'd0) begin
            fail_cnt++;
            $display("FAIL reset_release_early got=%h exp=0", alu_res_o);
        end
        step();
        assert_cnt++;
        if (alu_res_o !== 32'h1235 || st_data_o !== 32'h55 || dest_o !== 5'd9
            || wb_en_o !== 1'b1 || mem_sig_o !== 2'b10) begin
            fail_cnt++;
            $display("FAIL reset_first_capture got=%h/%h/%0d/%b/%b exp=1235/55/9/1/10",
                     alu_res_o, st_data_o, dest_o, wb_en_o, mem_sig_o);
        end
    endtask

    task automatic test_alu_sweep();
        logic [3:0]  cmds [6] = '{4'd0, 4'd2, 4'd8, 4'd9, 4'd10, 4'd6};
        logic [31:0] exps [6] = '{32'hF000_0013, 32'hF000_000B, 32'h0000_00F0,
                                  32'hFF00_0000, 32'h0F00_0000, 32'h0FFF_FFF0};
        clear_inputs();
        val1 = 32'hF000_000F; val2 = 32'd4;
        for (int i = 0; i < 6; i++) begin
            exe_cmd = cmds[i];
            step();
            assert_cnt++;
            if (alu_res_o !== exps[i]) begin
                fail_cnt++;
                $display("FAIL alu_sweep cmd=%b got=%h exp=%h", cmds[i], alu_res_o, exps[i]);
            end
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        src1 = 5'd3; val1 = 32'h33; val2 = 0; exe_cmd = 4'd0;
        mem_fw_en = 1; mem_fw_dest = 5'd3; mem_fw_data = 32'h11;
        wb_fw_en = 1;  wb_fw_dest = 5'd3;  wb_fw_data = 32'h22;
        step();
        assert_cnt++;
        if (alu_res_o !== 32'h11) begin
            fail_cnt++; $display("FAIL fwd_mem_priority got=%h exp=11", alu_res_o);
        end
        mem_fw_en = 0;
        step();
        assert_cnt++;
        if (alu_res_o !== 32'h22) begin
            fail_cnt++; $display("FAIL fwd_wb got=%h exp=22", alu_res_o);
        end
        mem_fw_en = 1; src1 = 0; mem_fw_dest = 0; wb_fw_dest = 0;
        step();
        assert_cnt++;
        if (alu_res_o !== 32'h33) begin
            fail_cnt++; $display("FAIL fwd_r0 got=%h exp=33", alu_res_o);
        end
    endtask

    task automatic test_branches();
        clear_inputs();
        pc = 32'h100; val2 = 32'hFFFF_FFFE;
        br_type = 2'b01; val1 = 0;
        #1;
        assert_cnt++;
        if (br_taken !== 1'b1 || br_addr !== 32'h0000_00F8) begin
            fail_cnt++; $display("FAIL br_bez got=%b/%h exp=1/000000f8", br_taken, br_addr);
        end
        br_type = 2'b10; val1 = 5; reg2 = 5;
        #1;
        assert_cnt++;
        if (br_taken !== 1'b0) begin
            fail_cnt++; $display("FAIL br_bne_equal got=%b exp=0", br_taken);
        end
        reg2 = 6;
        #1;
        assert_cnt++;
        if (br_taken !== 1'b1) begin
            fail_cnt++; $display("FAIL br_bne_differ got=%b exp=1", br_taken);
        end
        br_type = 2'b11;
        #1;
        assert_cnt++;
        if (br_taken !== 1'b1) begin
            fail_cnt++; $display("FAIL br_jmp got=%b exp=1", br_taken);
        end
        br_type = 2'b00;
        #1;
        assert_cnt++;
        if (br_taken !== 1'b0) begin
            fail_cnt++; $display("FAIL br_none got=%b exp=0", br_taken);
        end
    endtask

    task automatic test_freeze();
        clear_inputs();
        exe_cmd = 4'd0; val1 = 3; val2 = 4;
        step();
        assert_cnt++;
        if (alu_res_o !== 32'd7) begin
            fail_cnt++; $display("FAIL freeze_setup got=%h exp=7", alu_res_o);
        end
        freeze = 1; br_type = 2'b11;
        for (int i = 0; i < 3; i++) begin
            val1 = 32'd10 + i;
            #1;
            assert_cnt++;
            if (br_taken !== 1'b0) begin
                fail_cnt++; $display("FAIL freeze_br_taken cyc=%0d got=%b exp=0", i, br_taken);
            end
            step();
            assert_cnt++;
            if (alu_res_o !== 32'd7) begin
                fail_cnt++; $display("FAIL freeze_hold cyc=%0d got=%h exp=7", i, alu_res_o);
            end
        end
        freeze = 0;
        #1;
        assert_cnt++;
        if (br_taken !== 1'b1) begin
            fail_cnt++; $display("FAIL freeze_br_reassert got=%b exp=1", br_taken);
        end
        step();
        assert_cnt++;
        if (alu_res_o !== 32'd16) begin
            fail_cnt++; $display("FAIL freeze_release got=%h exp=10", alu_res_o);
        end
    endtask

    task automatic test_store();
        clear_inputs();
        mem_sig = 2'b01; wb_en = 0; src_st = 5'd4; reg2 = 0;
        wb_fw_en = 1; wb_fw_dest = 5'd4; wb_fw_data = 32'hABCD;
        step();
        assert_cnt++;
        if (st_data_o !== 32'hABCD || mem_sig_o !== 2'b01 || wb_en_o !== 1'b0) begin
            fail_cnt++;
            $display("FAIL store got=%h/%b/%b exp=0000abcd/01/0", st_data_o, mem_sig_o, wb_en_o);
        end
    endtask

    task automatic test_random();
        logic        e_wb;
        logic [1:0]  e_mem;
        logic [4:0]  e_dest;
        logic [31:0] e_alu, e_st;
        logic        e_tk;
        logic [31:0] e_addr;
        clear_inputs();
        e_wb = 0; e_mem = 0; e_dest = 0; e_alu = 0; e_st = 0;
        for (int i = 0; i < 300; i++) begin
            freeze  = (i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
            exe_cmd = 4'($urandom_range(0, 15));
            br_type = 2'($urandom);
            mem_sig = 2'($urandom);
            wb_en   = 1'($urandom);
            dest    = 5'($urandom);
            val1    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            val2    = $urandom;
            reg2    = ($urandom_range(0, 3) == 0) ? val1 : $urandom;
            pc      = $urandom;
            src1    = 5'($urandom_range(0, 3));
            src2    = 5'($urandom_range(0, 3));
            src_st  = 5'($urandom_range(0, 3));
            mem_fw_en   = 1'($urandom);
            mem_fw_dest = 5'($urandom_range(0, 3));
            mem_fw_data = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            wb_fw_en    = 1'($urandom);
            wb_fw_dest  = 5'($urandom_range(0, 3));
            wb_fw_data  = $urandom;
            #1;
            e_tk   = m_taken(br_type, m_fwd(val1, src1), m_fwd(reg2, src_st), freeze);
            e_addr = m_addr(pc, val2);
            assert_cnt++;
            if (br_taken !== e_tk || br_addr !== e_addr) begin
                fail_cnt++;
                $display("FAIL rand_branch it=%0d got=%b/%h exp=%b/%h", i, br_taken, br_addr, e_tk, e_addr);
            end
            if (!freeze) begin
                e_wb = wb_en; e_mem = mem_sig; e_dest = dest;
                e_alu = m_alu(exe_cmd, m_fwd(val1, src1), m_fwd(val2, src2));
                e_st  = m_fwd(reg2, src_st);
            end
            step();
            assert_cnt++;
            if (alu_res_o !== e_alu || st_data_o !== e_st || dest_o !== e_dest
                || wb_en_o !== e_wb || mem_sig_o !== e_mem) begin
                fail_cnt++;
                $display("FAIL rand_reg it=%0d got=%h/%h/%0d/%b/%b exp=%h/%h/%0d/%b/%b", i,
                         alu_res_o, st_data_o, dest_o, wb_en_o, mem_sig_o,
                         e_alu, e_st, e_dest, e_wb, e_mem);
            end
        end
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        step();
        test_reset();
        test_alu_sweep();
        test_forwarding();
        test_branches();
        test_freeze();
        test_store();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
